// File: rtl/fastica_iter_ctrl.sv
// fastica_iter_ctrl: control-only sequencer for the one-unit FastICA weight-update loop.
// Launches the mean and 3w units, strobes the subtractor, then runs normalize and convergence check.
module fastica_iter_ctrl #(
   parameter int MAX_ITER = 16,
   parameter int ITER_W   = 5
) (
   input  logic              clk_ctrl,
   input  logic              rst_ctrl,
   input  logic              start,
   output logic              mean_start,
   input  logic              mean_done,
   output logic              scale_start,
   input  logic              scale_done,
   output logic              en_sub,
   output logic              norm_start,
   input  logic              norm_done,
   output logic              conv_start,
   input  logic              conv_done,
   input  logic              conv_hit,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      IDLE, WAIT_MS, SUB, SUB_CAP, WAIT_NORM, WAIT_CONV, FIN
   } state_e;

   state_e            state_q;
   logic              mean_seen_q, scale_seen_q;
   logic              mean_start_q, scale_start_q, en_sub_q, norm_start_q, conv_start_q;
   logic              busy_q, done_q, converged_q;
   logic [ITER_W-1:0] iter_cnt_q;

   logic              ms_ready_d;
   logic [ITER_W-1:0] iter_cnt_d;
   logic              iter_cap_d;

   // A done arriving this very cycle counts as seen, so a same-cycle pair advances at once.
   assign ms_ready_d = (mean_seen_q | mean_done) & (scale_seen_q | scale_done);
   assign iter_cnt_d = iter_cnt_q + ITER_W'(1);
   assign iter_cap_d = (iter_cnt_d == ITER_W'(MAX_ITER));

   always_ff @(posedge clk_ctrl) begin
      if (rst_ctrl) begin
         state_q       <= IDLE;
         mean_seen_q   <= 1'b0;
         scale_seen_q  <= 1'b0;
         mean_start_q  <= 1'b0;
         scale_start_q <= 1'b0;
         en_sub_q      <= 1'b0;
         norm_start_q  <= 1'b0;
         conv_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         converged_q   <= 1'b0;
         iter_cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values and
         // the pulse defaults below are overridden only by the state that owns that pulse.
         mean_start_q  <= 1'b0;
         scale_start_q <= 1'b0;
         en_sub_q      <= 1'b0;
         norm_start_q  <= 1'b0;
         conv_start_q  <= 1'b0;
         done_q        <= 1'b0;

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q       <= WAIT_MS;
                  mean_start_q  <= 1'b1;
                  scale_start_q <= 1'b1;
                  busy_q        <= 1'b1;
                  iter_cnt_q    <= '0;
                  converged_q   <= 1'b0;
                  mean_seen_q   <= 1'b0;
                  scale_seen_q  <= 1'b0;
               end
            end
            WAIT_MS: begin
               if (ms_ready_d) begin
                  state_q      <= SUB;
                  en_sub_q     <= 1'b1;
                  mean_seen_q  <= 1'b0;
                  scale_seen_q <= 1'b0;
               end else begin
                  mean_seen_q  <= mean_seen_q | mean_done;
                  scale_seen_q <= scale_seen_q | scale_done;
               end
            end
            SUB: begin
               // Subtractor holds mean-3w only in the next cycle, so the normalizer is told then.
               state_q      <= SUB_CAP;
               norm_start_q <= 1'b1;
            end
            SUB_CAP: state_q <= WAIT_NORM;
            WAIT_NORM: begin
               if (norm_done) begin
                  state_q      <= WAIT_CONV;
                  conv_start_q <= 1'b1;
               end
            end
            WAIT_CONV: begin
               if (conv_done) begin
                  iter_cnt_q <= iter_cnt_d;
                  if (conv_hit || iter_cap_d) begin
                     state_q     <= FIN;
                     converged_q <= conv_hit;
                     done_q      <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q       <= WAIT_MS;
                     mean_start_q  <= 1'b1;
                     scale_start_q <= 1'b1;
                  end
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mean_start  = mean_start_q;
   assign scale_start = scale_start_q;
   assign en_sub      = en_sub_q;
   assign norm_start  = norm_start_q;
   assign conv_start  = conv_start_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign converged   = converged_q;
   assign iter_cnt    = iter_cnt_q;

endmodule

// File: tb/tb_fastica_iter_ctrl.sv
// Scoreboard bench for fastica_iter_ctrl: a timeline model predicts every output pulse of a run,
// a responder plays the arithmetic units, and a monitor pops and compares each observed pulse.
module tb_fastica_iter_ctrl;

   localparam int          TB_MAX = 4;
   localparam int          TB_W   = 5;
   localparam logic [27:0] MEAN_V = 28'h0000100;
   localparam logic [27:0] TW_V   = 28'h0000030;
   localparam logic [27:0] DIFF_V = 28'h00000D0;

   typedef enum int {EV_MS, EV_EN, EV_NS, EV_CS, EV_DONE} ev_e;
   typedef struct {
      int  cyc;
      ev_e kind;
      bit  conv;
      int  iter;
   } exp_t;

   logic            clk_ctrl = 1'b0;
   logic            rst_ctrl = 1'b1;
   logic            start = 1'b0;
   logic            mean_done = 1'b0, scale_done = 1'b0, norm_done = 1'b0;
   logic            conv_done = 1'b0, conv_hit = 1'b0;
   logic            mean_start, scale_start, en_sub, norm_start, conv_start;
   logic            busy, done, converged;
   logic [TB_W-1:0] iter_cnt;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t sb[$];

   int   dm[TB_MAX], ds[TB_MAX], dn[TB_MAX], dc[TB_MAX];
   bit   hit[TB_MAX];
   int   it = 0;
   bit   spur_en = 1'b0;
   bit   man_norm = 1'b0;

   logic [27:0] w[16];

   fastica_iter_ctrl #(.MAX_ITER(TB_MAX), .ITER_W(TB_W)) dut (
      .clk_ctrl   (clk_ctrl),
      .rst_ctrl   (rst_ctrl),
      .start      (start),
      .mean_start (mean_start),
      .mean_done  (mean_done),
      .scale_start(scale_start),
      .scale_done (scale_done),
      .en_sub     (en_sub),
      .norm_start (norm_start),
      .norm_done  (norm_done),
      .conv_start (conv_start),
      .conv_done  (conv_done),
      .conv_hit   (conv_hit),
      .busy       (busy),
      .done       (done),
      .converged  (converged),
      .iter_cnt   (iter_cnt)
   );

   always #5 clk_ctrl = ~clk_ctrl;

   initial forever begin
      @(posedge clk_ctrl);
      cyc++;
   end

   // Behavioural subtractor: captures mean-3w when enabled, otherwise passes 3w through.
   always @(posedge clk_ctrl)
      for (int i = 0; i < 16; i++) w[i] <= en_sub ? (MEAN_V - TW_V) : TW_V;

   task automatic check(input string name, input bit ok, input string got, input string want);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %s, want %s (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic bit w_all(input logic [27:0] v);
      bit ok = 1'b1;
      for (int i = 0; i < 16; i++) ok &= (w[i] === v);
      return ok;
   endfunction

   task automatic expect_ev(input ev_e k);
      exp_t e;
      check("pulse_expected", sb.size() > 0, $sformatf("%s pulse", k.name()), "no pulse");
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check($sformatf("event_%s", k.name()), (e.kind == k) && (e.cyc == cyc),
            $sformatf("%s@%0d", k.name(), cyc), $sformatf("%s@%0d", e.kind.name(), e.cyc));
      if (k == EV_DONE)
         check("done_result", (converged == e.conv) && (iter_cnt == e.iter) && !busy,
               $sformatf("conv=%0b iter=%0d busy=%0b", converged, iter_cnt, busy),
               $sformatf("conv=%0b iter=%0d busy=0", e.conv, e.iter));
      else
         check("busy_in_run", busy == 1'b1, $sformatf("busy=%0b", busy), "busy=1");
   endtask

   // Monitor: samples on the falling edge, pops one expectation per observed pulse.
   initial begin
      bit prev_ns = 1'b0;
      forever begin
         @(negedge clk_ctrl);
         if (prev_ns)
            check("sub_reload", w_all(TW_V), $sformatf("w0=%h", w[0]), $sformatf("all %h", TW_V));
         prev_ns = norm_start;
         if (mean_start || scale_start) begin
            check("ms_pair", mean_start == scale_start,
                  $sformatf("mean=%0b scale=%0b", mean_start, scale_start), "equal");
            expect_ev(EV_MS);
         end
         if (en_sub) expect_ev(EV_EN);
         if (norm_start) begin
            expect_ev(EV_NS);
            check("sub_capture", w_all(DIFF_V), $sformatf("w0=%h", w[0]), $sformatf("all %h", DIFF_V));
         end
         if (conv_start) expect_ev(EV_CS);
         if (done) expect_ev(EV_DONE);
      end
   end

   // Responder: plays the arithmetic units with per-iteration latencies.
   initial begin
      int mean_due = -1, scale_due = -1, norm_due = -1, conv_due = -1, spur_due = -1;
      int dn_cur = 0, dc_cur = 0, k;
      bit hit_cur = 1'b0;
      forever begin
         @(negedge clk_ctrl);
         if (rst_ctrl) begin
            mean_due = -1; scale_due = -1; norm_due = -1; conv_due = -1; spur_due = -1;
         end
         if (mean_start) begin
            k         = (it < TB_MAX) ? it : TB_MAX - 1;
            mean_due  = cyc + dm[k];
            scale_due = cyc + ds[k];
            dn_cur    = dn[k];
            dc_cur    = dc[k];
            hit_cur   = hit[k];
            if (spur_en) spur_due = cyc + 1;
            it++;
         end
         if (norm_start) norm_due = cyc + 1 + dn_cur;
         if (conv_start) conv_due = cyc + dc_cur;
         mean_done  = (cyc == mean_due);
         scale_done = (cyc == scale_due);
         norm_done  = (cyc == norm_due) || (cyc == spur_due) || man_norm;
         conv_done  = (cyc == conv_due) || (cyc == spur_due);
         conv_hit   = (cyc == conv_due) ? hit_cur : (cyc == spur_due) ? 1'b1 : 1'($urandom & 1);
      end
   end

   task automatic tick();
      @(posedge clk_ctrl);
      #2;
   endtask

   task automatic fill(input int a, input int b, input int c, input int d);
      for (int k = 0; k < TB_MAX; k++) begin
         dm[k] = a; ds[k] = b; dn[k] = c; dc[k] = d; hit[k] = 1'b0;
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < TB_MAX; k++) begin
         dm[k]  = $urandom_range(0, 7);
         ds[k]  = $urandom_range(0, 7);
         dn[k]  = $urandom_range(0, 4);
         dc[k]  = $urandom_range(0, 4);
         hit[k] = ($urandom_range(0, 2) == 0);
      end
   endtask

   task automatic push(input int c, input ev_e k);
      sb.push_back('{cyc: c, kind: k, conv: 1'b0, iter: 0});
   endtask

   // Timeline model: start sampled at the end of cycle c0; each wait lasts its latency plus the
   // fixed SUB/SUB_CAP steps. stop_iter >= 0 truncates the run after that iteration's norm_start.
   task automatic plan(input int c0, input int stop_iter, output bit econv, output int eiter);
      int s, e, cs, cd;
      s = c0 + 1;
      econv = 1'b0;
      eiter = 0;
      for (int k = 0; k < TB_MAX; k++) begin
         push(s, EV_MS);
         e = s + ((dm[k] > ds[k]) ? dm[k] : ds[k]) + 1;
         push(e, EV_EN);
         push(e + 1, EV_NS);
         if (k == stop_iter) return;
         cs = e + 3 + dn[k];
         push(cs, EV_CS);
         cd = cs + dc[k];
         if (hit[k] || (k + 1 == TB_MAX)) begin
            econv = hit[k];
            eiter = k + 1;
            sb.push_back('{cyc: cd + 1, kind: EV_DONE, conv: hit[k], iter: k + 1});
            return;
         end
         s = cd + 1;
      end
   endtask

   task automatic launch(input bit hold, input int stop_iter, output bit econv, output int eiter);
      it    = 0;
      start = 1'b1;
      plan(cyc, stop_iter, econv, eiter);
      tick();
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(output int dcyc);
      dcyc = -1;
      for (int i = 0; i < 600; i++) begin
         if (done) begin
            dcyc = cyc;
            return;
         end
         tick();
      end
      check("done_timeout", done == 1'b1, "no done within 600 cycles", "done pulse");
   endtask

   task automatic check_idle(input bit econv, input int eiter);
      repeat (3) tick();
      check("held_result", !busy && (converged == econv) && (iter_cnt == eiter),
            $sformatf("busy=%0b conv=%0b iter=%0d", busy, converged, iter_cnt),
            $sformatf("busy=0 conv=%0b iter=%0d", econv, eiter));
   endtask

   task automatic run(input bit econv_dummy);
      bit econv;
      int eiter, dcyc;
      launch(1'b0, -1, econv, eiter);
      wait_done(dcyc);
      check_idle(econv, eiter);
   endtask

   initial begin
      bit econv;
      int eiter, d1, d2;

      fill(0, 0, 0, 0);
      rst_ctrl = 1'b1;
      repeat (3) tick();
      rst_ctrl = 1'b0;
      check("reset_state",
            {mean_start, scale_start, en_sub, norm_start, conv_start, busy, done, converged, iter_cnt} == '0,
            $sformatf("busy=%0b done=%0b conv=%0b iter=%0d", busy, done, converged, iter_cnt), "all 0");
      tick();

      // Minimum-latency units, convergence on the third iteration.
      fill(0, 0, 0, 0);
      hit[2] = 1'b1;
      run(1'b0);

      // Reset in the second iteration's WAIT_NORM, then a late norm_done.
      fill(0, 0, 0, 0);
      dn[1] = 30;
      launch(1'b0, 1, econv, eiter);
      repeat (8) tick();
      rst_ctrl = 1'b1;
      tick();
      rst_ctrl = 1'b0;
      check("reset_mid_run",
            {mean_start, scale_start, en_sub, norm_start, conv_start, busy, done, converged, iter_cnt} == '0,
            $sformatf("busy=%0b done=%0b conv=%0b iter=%0d", busy, done, converged, iter_cnt), "all 0");
      tick();
      man_norm = 1'b1;
      tick();
      man_norm = 1'b0;
      repeat (4) tick();
      check("post_reset_idle", !busy && !done && (iter_cnt == 0),
            $sformatf("busy=%0b done=%0b iter=%0d", busy, done, iter_cnt), "idle");

      // Iteration cap: never converges.
      fill_rand();
      for (int k = 0; k < TB_MAX; k++) hit[k] = 1'b0;
      run(1'b0);

      // Mean/scale done ordering: late mean, late scale, coincident.
      fill(0, 0, 0, 0); dm[0] = 7; ds[0] = 2; hit[0] = 1'b1;
      run(1'b0);
      fill(0, 0, 0, 0); dm[0] = 2; ds[0] = 7; hit[0] = 1'b1;
      run(1'b0);
      fill(0, 0, 0, 0); dm[0] = 4; ds[0] = 4; hit[0] = 1'b1;
      run(1'b0);

      // start held through a run plus spurious norm/conv dones inside WAIT_MS.
      spur_en = 1'b1;
      fill(3, 1, 0, 0);
      hit[1] = 1'b1;
      launch(1'b1, -1, econv, eiter);
      wait_done(d1);
      fill_rand();
      it = 0;
      plan(d1 + 1, -1, econv, eiter);
      tick();
      tick();
      start = 1'b0;
      wait_done(d2);
      check_idle(econv, eiter);
      spur_en = 1'b0;

      for (int r = 0; r < 20; r++) begin
         fill_rand();
         run(1'b0);
      end

      repeat (5) tick();
      check("scoreboard_drained", sb.size() == 0, $sformatf("%0d left", sb.size()), "0 left");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, want finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
